ddr2_fifo_responder: RTL and testbench

- Memory-side responder for the DDR2 FIFO interface that the cache drives.
- Accepts commands on the address/command FIFO and write data on the write-data FIFO; returns 128-bit read beats through the read-data FIFO.
- Backed by an internal line-wide memory; acts as the simulation/FPGA stand-in for the DDR2 controller.
- Requests are serviced strictly in order, one at a time.

---
 rtl/ddr2_fifo_responder_pkg.sv | 34 +++
 rtl/ddr2_fifo_responder_sync_fifo.sv | 87 ++++++++
 rtl/ddr2_fifo_responder.sv | 219 +++++++++++++++++++++
 tb/tb_ddr2_fifo_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_fifo_responder_pkg.sv
// Shared constants and types for the DDR2 FIFO responder: command encodings,
// beat/line widths, address slicing and the engine state type.
package ddr2_fifo_responder_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam int BEAT_W        = 128;
   localparam int MASK_W        = 16;
   localparam int LINE_W        = 256;
   localparam int CMD_W         = 3;
   localparam int ADDR_W        = 31;
   localparam int ADDR_LINE_LSB = 3;
   localparam int LAT_W         = 4;

   localparam int CMDQ_W = CMD_W + ADDR_W;
   localparam int WDQ_W  = MASK_W + BEAT_W;

   typedef enum logic [2:0] {
      IDLE,
      WR0,
      WR1,
      RLAT,
      RD0,
      RD1
   } eng_state_e;

   // Beat 0 travels in the upper half of the line, beat 1 in the lower half.
   function automatic logic [BEAT_W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                                   input logic              upper);
      return upper ? line[LINE_W-1:BEAT_W] : line[BEAT_W-1:0];
   endfunction

endpackage

// File: rtl/ddr2_fifo_responder_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags, an occupancy count and
// optional first-word-fall-through output (dout reads zero while empty).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter bit FWFT  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       din,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   // A full FIFO still accepts a push in the cycle it is being popped.
   always_comb begin
      do_pop   = rd_en & ~empty_q;
      do_push  = wr_en & (~full_q | do_pop);
      overflow = wr_en & full_q & ~do_pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == FULL_CNT);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   generate
      if (FWFT) begin : g_fwft
         assign dout = empty_q ? '0 : mem_q[rd_ptr_q];
      end else begin : g_reg
         logic [WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (!rst)        dout_q <= '0;
            else if (do_pop) dout_q <= mem_q[rd_ptr_q];
         end
         assign dout = dout_q;
      end
   endgenerate

   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/ddr2_fifo_responder.sv
// Memory-side DDR2 FIFO responder: services write/read commands strictly in
// order against a line-wide backing memory, one command at a time.
//
//  state | meaning
//  IDLE  | waiting for a serviceable command at the head of the command FIFO
//  WR0   | merge write beat 0 into the upper half of the line
//  WR1   | merge write beat 1 into the lower half of the line
//  RLAT  | read latency countdown; memory read issued on the last cycle
//  RD0   | push upper half of the line into the read-data FIFO
//  RD1   | push lower half of the line into the read-data FIFO
module ddr2_fifo_responder
   import ddr2_fifo_responder_pkg::*;
#(
   parameter int LINE_AW      = 10,
   parameter int CMD_DEPTH    = 4,
   parameter int WDF_DEPTH    = 8,
   parameter int RDF_DEPTH    = 4,
   parameter int READ_LATENCY = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CMD_W-1:0]    af_cmd_din,
   input  logic [ADDR_W-1:0]   af_addr_din,
   input  logic                af_wr_en,
   output logic                af_full,
   input  logic [BEAT_W-1:0]   wdf_din,
   input  logic [MASK_W-1:0]   wdf_mask_din,
   input  logic                wdf_wr_en,
   output logic                wdf_full,
   input  logic                rdf_rd_en,
   output logic                rdf_valid,
   output logic [BEAT_W-1:0]   rdf_dout,
   output logic                busy,
   output logic                err_overflow,
   output logic                err_bad_cmd
);

   localparam int CMD_CW   = $clog2(CMD_DEPTH) + 1;
   localparam int WDF_CW   = $clog2(WDF_DEPTH) + 1;
   localparam int RDF_CW   = $clog2(RDF_DEPTH) + 1;
   localparam int LINE_MSB = LINE_AW + ADDR_LINE_LSB - 1;

   logic [CMDQ_W-1:0]  cmd_head;
   logic               cmd_empty, cmd_pop, cmd_ovf;
   logic [CMD_CW-1:0]  cmd_count;
   logic [CMD_W-1:0]   cmd_op;
   logic [ADDR_W-1:0]  cmd_addr;
   logic [LINE_AW-1:0] cmd_line;

   logic [WDQ_W-1:0]   wdf_head;
   logic               wdf_empty, wdf_pop, wdf_ovf;
   logic [WDF_CW-1:0]  wdf_count;
   logic [MASK_W-1:0]  wdf_mask;
   logic [BEAT_W-1:0]  wdf_data;

   logic [BEAT_W-1:0]  rdf_push_data;
   logic               rdf_empty, rdf_full, rdf_push, rdf_pop, rdf_ovf;
   logic [RDF_CW-1:0]  rdf_count;
   logic [RDF_CW:0]    rdf_room;

   eng_state_e         state_q, state_d;
   logic [LINE_AW-1:0] line_q, line_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               err_bad_cmd_q, err_bad_cmd_d;
   logic               err_overflow_q, err_overflow_d;
   logic               mem_we_hi, mem_we_lo, mem_re;

   logic [LINE_W-1:0]  mem_q [2**LINE_AW];
   logic [LINE_W-1:0]  rd_line_q;

   sync_fifo #(.WIDTH(CMDQ_W), .DEPTH(CMD_DEPTH), .FWFT(1'b1)) u_cmd_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (af_wr_en),
      .din      ({af_cmd_din, af_addr_din}),
      .rd_en    (cmd_pop),
      .dout     (cmd_head),
      .full     (af_full),
      .empty    (cmd_empty),
      .count    (cmd_count),
      .overflow (cmd_ovf)
   );

   sync_fifo #(.WIDTH(WDQ_W), .DEPTH(WDF_DEPTH), .FWFT(1'b1)) u_wdf_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wdf_wr_en),
      .din      ({wdf_mask_din, wdf_din}),
      .rd_en    (wdf_pop),
      .dout     (wdf_head),
      .full     (wdf_full),
      .empty    (wdf_empty),
      .count    (wdf_count),
      .overflow (wdf_ovf)
   );

   sync_fifo #(.WIDTH(BEAT_W), .DEPTH(RDF_DEPTH), .FWFT(1'b1)) u_rdf_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (rdf_push),
      .din      (rdf_push_data),
      .rd_en    (rdf_rd_en),
      .dout     (rdf_dout),
      .full     (rdf_full),
      .empty    (rdf_empty),
      .count    (rdf_count),
      .overflow (rdf_ovf)
   );

   assign {cmd_op, cmd_addr}   = cmd_head;
   assign cmd_line             = cmd_addr[LINE_MSB:ADDR_LINE_LSB];
   assign {wdf_mask, wdf_data} = wdf_head;

   // Free read-data slots once this cycle's consumer pop has been counted.
   assign rdf_pop  = rdf_rd_en & ~rdf_empty;
   assign rdf_room = (RDF_CW+1)'(RDF_DEPTH) - {1'b0, rdf_count}
                   + {{RDF_CW{1'b0}}, rdf_pop};

   always_comb begin
      state_d        = state_q;
      line_d         = line_q;
      lat_d          = lat_q;
      err_bad_cmd_d  = err_bad_cmd_q;
      err_overflow_d = err_overflow_q | cmd_ovf | wdf_ovf;
      cmd_pop        = 1'b0;
      wdf_pop        = 1'b0;
      rdf_push       = 1'b0;
      rdf_push_data  = '0;
      mem_we_hi      = 1'b0;
      mem_we_lo      = 1'b0;
      mem_re         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!cmd_empty) begin
               if (cmd_op == CMD_WRITE) begin
                  if (wdf_count >= WDF_CW'(2)) begin
                     cmd_pop = 1'b1;
                     line_d  = cmd_line;
                     state_d = WR0;
                  end
               end else if (cmd_op == CMD_READ) begin
                  if (rdf_room >= (RDF_CW+1)'(2)) begin
                     cmd_pop = 1'b1;
                     line_d  = cmd_line;
                     lat_d   = LAT_W'(READ_LATENCY - 1);
                     state_d = RLAT;
                  end
               end else begin
                  cmd_pop       = 1'b1;
                  err_bad_cmd_d = 1'b1;
               end
            end
         end
         WR0: begin
            wdf_pop   = 1'b1;
            mem_we_hi = rst;
            state_d   = WR1;
         end
         WR1: begin
            wdf_pop   = 1'b1;
            mem_we_lo = rst;
            state_d   = IDLE;
         end
         RLAT: begin
            if (lat_q == '0) begin
               mem_re  = 1'b1;
               state_d = RD0;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         RD0: begin
            rdf_push      = 1'b1;
            rdf_push_data = line_beat(rd_line_q, 1'b1);
            state_d       = RD1;
         end
         RD1: begin
            rdf_push      = 1'b1;
            rdf_push_data = line_beat(rd_line_q, 1'b0);
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         line_q         <= '0;
         lat_q          <= '0;
         err_bad_cmd_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         line_q         <= line_d;
         lat_q          <= lat_d;
         err_bad_cmd_q  <= err_bad_cmd_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   // Backing memory is never cleared; a cleared mask bit means "write this byte".
   always_ff @(posedge clk) begin
      for (int b = 0; b < MASK_W; b++) begin
         if (mem_we_hi && !wdf_mask[b]) mem_q[line_q][BEAT_W + 8*b +: 8] <= wdf_data[8*b +: 8];
         if (mem_we_lo && !wdf_mask[b]) mem_q[line_q][8*b +: 8]          <= wdf_data[8*b +: 8];
      end
      if (mem_re) rd_line_q <= mem_q[line_q];
   end

   assign rdf_valid    = ~rdf_empty;
   assign busy         = (state_q != IDLE) | ~cmd_empty | ~wdf_empty | ~rdf_empty;
   assign err_overflow = err_overflow_q;
   assign err_bad_cmd  = err_bad_cmd_q;

   logic unused_ok;
   assign unused_ok = ^{cmd_count, rdf_full, rdf_ovf, cmd_addr};

endmodule

// File: tb/tb_ddr2_fifo_responder.sv
// Scoreboarded bench for ddr2_fifo_responder: stimulus updates a line-level
// memory model and queues expected read beats; a monitor checks every pop.
module tb_ddr2_fifo_responder;

   localparam int LINE_AW   = 10;
   localparam int CMD_DEPTH = 4;
   localparam int WDF_DEPTH = 8;
   localparam int RDF_DEPTH = 4;
   localparam int RL        = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [2:0]   af_cmd_din = '0;
   logic [30:0]  af_addr_din = '0;
   logic         af_wr_en = 1'b0;
   logic         af_full;
   logic [127:0] wdf_din = '0;
   logic [15:0]  wdf_mask_din = '0;
   logic         wdf_wr_en = 1'b0;
   logic         wdf_full;
   logic         rdf_rd_en = 1'b0;
   logic         rdf_valid;
   logic [127:0] rdf_dout;
   logic         busy;
   logic         err_overflow;
   logic         err_bad_cmd;

   ddr2_fifo_responder #(
      .LINE_AW(LINE_AW), .CMD_DEPTH(CMD_DEPTH), .WDF_DEPTH(WDF_DEPTH),
      .RDF_DEPTH(RDF_DEPTH), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .rst(rst),
      .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .af_full(af_full),
      .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .wdf_full(wdf_full),
      .rdf_rd_en(rdf_rd_en), .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
      .busy(busy), .err_overflow(err_overflow), .err_bad_cmd(err_bad_cmd)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_err = 0;
   int           rd_mode = 0;   // 0 hold low, 1 random, 2 always high
   logic [127:0] exp_q [$];
   logic [255:0] mdl [1 << LINE_AW];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int line_of(input logic [30:0] addr);
      return int'((addr >> 3) % (1 << LINE_AW));
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Monitor: every beat the consumer actually takes must match the queue head.
   always @(negedge clk) begin
      if (rst && rdf_valid && rdf_rd_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_beat: got %h expected no beat", rdf_dout);
         end else begin
            chk("rd_beat", rdf_dout, exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (rd_mode)
         0:       rdf_rd_en = 1'b0;
         1:       rdf_rd_en = ($urandom_range(0, 3) != 0);
         default: rdf_rd_en = 1'b1;
      endcase
   end

   task automatic wait_room(input bit need_af, input bit need_wdf);
      for (int i = 0; i < 1000; i++) begin
         if ((!need_af || !af_full) && (!need_wdf || !wdf_full)) return;
         @(posedge clk); #1;
      end
      n_cmp++;
      n_err++;
      $display("FAIL room_timeout: af_full=%b wdf_full=%b expected a free slot", af_full, wdf_full);
   endtask

   task automatic do_write(input logic [30:0] addr, input logic [127:0] d0, input logic [15:0] m0,
                           input logic [127:0] d1, input logic [15:0] m1);
      int l;
      wait_room(1, 1);
      af_cmd_din = 3'b000; af_addr_din = addr; af_wr_en = 1'b1;
      wdf_din = d0; wdf_mask_din = m0; wdf_wr_en = 1'b1;
      @(posedge clk); #1;
      af_wr_en = 1'b0; wdf_wr_en = 1'b0;
      wait_room(0, 1);
      wdf_din = d1; wdf_mask_din = m1; wdf_wr_en = 1'b1;
      @(posedge clk); #1;
      wdf_wr_en = 1'b0;
      l = line_of(addr);
      for (int b = 0; b < 16; b++) begin
         if (!m0[b]) mdl[l][128 + 8*b +: 8] = d0[8*b +: 8];
         if (!m1[b]) mdl[l][8*b +: 8]       = d1[8*b +: 8];
      end
   endtask

   task automatic do_cmd_raw(input logic [2:0] cmd, input logic [30:0] addr);
      wait_room(1, 0);
      af_cmd_din = cmd; af_addr_din = addr; af_wr_en = 1'b1;
      @(posedge clk); #1;
      af_wr_en = 1'b0;
   endtask

   task automatic do_read(input logic [30:0] addr, input bit expect_data);
      logic [255:0] ln;
      do_cmd_raw(3'b001, addr);
      if (expect_data) begin
         ln = mdl[line_of(addr)];
         exp_q.push_back(ln[255:128]);
         exp_q.push_back(ln[127:0]);
      end
   endtask

   task automatic drain();
      rd_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0 && !busy) return;
         @(posedge clk); #1;
      end
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding busy=%b expected 0 and 0", exp_q.size(), busy);
   endtask

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: time limit reached with %0d beats outstanding", exp_q.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int accepted;
      int lines [8];
      logic [30:0] a;
      lines = '{10'h010, 10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h001, 10'h200, 10'h0FF};

      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_af_full", af_full, 1'b0);
      chk_bit("rst_wdf_full", wdf_full, 1'b0);
      chk_bit("rst_rdf_valid", rdf_valid, 1'b0);
      chk("rst_rdf_dout", rdf_dout, 128'h0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_err_overflow", err_overflow, 1'b0);
      chk_bit("rst_err_bad_cmd", err_bad_cmd, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Full-line write, then a read with first-beat latency measured from the push edge.
      do_write(31'h80, {8{16'hAAAA}}, 16'h0000, {8{16'h5555}}, 16'h0000);
      drain();
      rd_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      do_read(31'h80, 1'b1);
      chk_bit("busy_after_read_push", busy, 1'b1);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (rdf_valid) begin
            k = i;
            break;
         end
      end
      // Command pops one cycle after its push edge, then READ_LATENCY+1 cycles to valid.
      chk_int("read_latency", k, RL + 2);
      drain();

      // Partial write: only byte 0 of beat 0 is enabled.
      do_write(31'h80, 128'hEE, 16'hFFFE, 128'h0123, 16'hFFFF);
      do_read(31'h80, 1'b1);
      drain();

      // Line 0x400 aliases line 0 with LINE_AW=10.
      do_write(31'h2000, rnd128(), 16'h0000, rnd128(), 16'h0000);
      do_read(31'h0, 1'b1);
      do_read(31'h7FFF_E005, 1'b1);
      drain();

      // Fill everything with the consumer stalled, then overflow the command FIFO.
      rd_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_bit("err_overflow_clear", err_overflow, 1'b0);
      accepted = 0;
      for (int c = 0; c < 40; c++) begin
         if (!af_full) begin
            a = (accepted % 2 == 1) ? 31'h80 : 31'h0;
            af_cmd_din = 3'b001; af_addr_din = a; af_wr_en = 1'b1;
            exp_q.push_back(mdl[line_of(a)][255:128]);
            exp_q.push_back(mdl[line_of(a)][127:0]);
            accepted++;
         end else begin
            af_wr_en = 1'b0;
         end
         @(posedge clk); #1;
      end
      af_wr_en = 1'b0;
      chk_int("reads_accepted_stalled", accepted, CMD_DEPTH + RDF_DEPTH / 2);
      chk_bit("af_full_stalled", af_full, 1'b1);
      chk_bit("rdf_valid_stalled", rdf_valid, 1'b1);
      chk_bit("busy_stalled", busy, 1'b1);
      chk_bit("err_overflow_before", err_overflow, 1'b0);
      af_cmd_din = 3'b001; af_addr_din = 31'h80; af_wr_en = 1'b1;
      @(posedge clk); #1;
      af_wr_en = 1'b0;
      @(posedge clk); #1;
      chk_bit("err_overflow_set", err_overflow, 1'b1);
      drain();
      chk_bit("err_overflow_sticky", err_overflow, 1'b1);

      // Illegal command is consumed; the following read still completes.
      chk_bit("err_bad_cmd_clear", err_bad_cmd, 1'b0);
      do_cmd_raw(3'b010, 31'h80);
      do_read(31'h0, 1'b1);
      drain();
      chk_bit("err_bad_cmd_set", err_bad_cmd, 1'b1);

      // Randomized traffic over a small line set with random upper/lower address bits.
      foreach (lines[i]) begin
         a = 31'($urandom());
         a[12:3] = 10'(lines[i]);
         do_write(a, rnd128(), 16'h0000, rnd128(), 16'h0000);
      end
      rd_mode = 1;
      for (int n = 0; n < 80; n++) begin
         a = 31'($urandom());
         a[12:3] = 10'(lines[$urandom_range(0, 7)]);
         if ($urandom_range(0, 1) == 0)
            do_write(a, rnd128(), ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom()),
                     rnd128(), ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom()));
         else
            do_read(a, 1'b1);
      end
      drain();

      // Reset while a read is in its latency phase.
      rd_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      do_read(31'h80, 1'b0);
      @(posedge clk); #1;
      chk_bit("busy_in_rlat", busy, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_bit("mid_rst_rdf_valid", rdf_valid, 1'b0);
      chk_bit("mid_rst_busy", busy, 1'b0);
      chk_bit("mid_rst_af_full", af_full, 1'b0);
      chk_bit("mid_rst_wdf_full", wdf_full, 1'b0);
      chk("mid_rst_rdf_dout", rdf_dout, 128'h0);
      chk_bit("mid_rst_err_overflow", err_overflow, 1'b0);
      chk_bit("mid_rst_err_bad_cmd", err_bad_cmd, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_bit("post_rst_rdf_valid", rdf_valid, 1'b0);
      do_read(31'h80, 1'b1);
      do_read(31'h0, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
